calc_op_sequencer: RTL and testbench

// - Sequences the calculator's operand memory: accepts one command at a time (push/pop/ALU op),

---
 rtl/calc_pkg.sv | 38 +++
 rtl/calc_alu.sv | 46 ++++
 rtl/calc_op_sequencer.sv | 271 +++++++++++++++++++++++++++
 tb/tb_calc_op_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and defaults for the calculator operand sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: op-code enum, sequencer state enum, DEPTH/IN_W/DATA_W defaults,
//           and the binary-op classification helper.
package calc_pkg;

    localparam int DEPTH_DEF  = 32;
    localparam int IN_W_DEF   = 16;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [2:0] {
        OP_PUSH = 3'd0,
        OP_POP  = 3'd1,
        OP_ADD  = 3'd2,
        OP_SUB  = 3'd3,
        OP_AND  = 3'd4,
        OP_OR   = 3'd5,
        OP_CLR  = 3'd6,
        OP_RSVD = 3'd7
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_A   = 3'd1,
        ST_WAIT_A = 3'd2,
        ST_RD_B   = 3'd3,
        ST_WAIT_B = 3'd4,
        ST_EXEC   = 3'd5,
        ST_WR     = 3'd6,
        ST_DONE   = 3'd7
    } state_t;

    function automatic logic is_binop(input op_t op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

endpackage

// File: rtl/calc_alu.sv
// Combinational calculator ALU: R = B op A (SUB computes B - A).
// Latency: 0 cycles (pure combinational; the sequencer registers R).
// Backpressure: none.
// Ports: i_op (op code), i_a (top / head operand), i_b (next operand), o_r (result).
// Build option CALC_SAT_EN: when defined, ADD saturates at all-ones and SUB clamps
// at zero; otherwise both wrap modulo 2^DATA_W. AND/OR are unaffected.
module calc_alu
    import calc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  op_t               i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_r
);

    logic [DATA_W-1:0] w_add;
    logic [DATA_W-1:0] w_sub;

`ifdef CALC_SAT_EN
    // One extra bit holds the carry (ADD) or borrow (SUB) used for clamping.
    logic [DATA_W:0] w_sum;
    logic [DATA_W:0] w_diff;

    assign w_sum  = {1'b0, i_b} + {1'b0, i_a};
    assign w_diff = {1'b0, i_b} - {1'b0, i_a};
    assign w_add  = w_sum[DATA_W]  ? '1 : w_sum[DATA_W-1:0];
    assign w_sub  = w_diff[DATA_W] ? '0 : w_diff[DATA_W-1:0];
`else
    assign w_add = i_b + i_a;
    assign w_sub = i_b - i_a;
`endif

    always_comb begin
        o_r = '0;
        case (i_op)
            OP_ADD:  o_r = w_add;
            OP_SUB:  o_r = w_sub;
            OP_AND:  o_r = i_b & i_a;
            OP_OR:   o_r = i_b | i_a;
            default: o_r = '0;
        endcase
    end

endmodule

// File: rtl/calc_op_sequencer.sv
// Calculator operand sequencer: runs PUSH/POP/ALU/CLR commands against a
// single-port sync-read RAM in stack (LIFO) or queue (FIFO) order.
// Latency: accept-to-done PUSH 2, POP 3, binary op 7, CLR/rejected 1 cycle.
// Backpressure: cmd_ready is high only in IDLE; one command in flight at a time.
// Ports: clk/rst (sync active-high); mode_q (0 stack, 1 queue, latched on rst/CLR);
//        cmd_valid/cmd_ready/cmd_op/cmd_data command handshake; mem_we/mem_addr/
//        mem_wdata/mem_rdata RAM port (rdata one cycle after addr); disp display
//        value; done/err completion pulses; empty/full/count occupancy.
// Build option CALC_SAT_EN selects saturating ADD/SUB in the ALU.
module calc_op_sequencer
    import calc_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int IN_W   = IN_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode_q,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_op,
    input  logic [IN_W-1:0]          cmd_data,
    output logic                     mem_we,
    output logic [$clog2(DEPTH)-1:0] mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic [DATA_W-1:0]        disp,
    output logic                     done,
    output logic                     err,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int              AW       = $clog2(DEPTH);
    localparam int              CW       = AW + 1;
    localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);

    state_t            r_state;
    state_t            w_state_nxt;

    op_t               r_op;
    logic [IN_W-1:0]   r_data;
    logic              r_err;
    logic              r_mode;
    logic [AW-1:0]     r_head;
    logic [AW-1:0]     r_tail;
    logic [CW-1:0]     r_count;
    logic              r_empty;
    logic              r_full;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_res;
    logic [DATA_W-1:0] r_disp;

    op_t               w_cmd_op;
    logic              w_accept;
    logic              w_reject;
    logic [DATA_W-1:0] w_alu_r;
    logic [DATA_W-1:0] w_push_val;
    logic [AW-1:0]     w_addr_a;
    logic [AW-1:0]     w_addr_b;
    logic [AW-1:0]     w_addr_wr;

    logic              w_commit;
    logic [CW-1:0]     w_count_nxt;
    logic [AW-1:0]     w_head_nxt;
    logic [AW-1:0]     w_tail_nxt;
    logic [DATA_W-1:0] w_disp_nxt;

    assign w_cmd_op   = op_t'(cmd_op);
    assign w_accept   = cmd_valid && (r_state == ST_IDLE);
    assign w_push_val = DATA_W'(r_data);

    // Reject decision uses the registered occupancy flags at acceptance.
    always_comb begin
        w_reject = 1'b0;
        case (w_cmd_op)
            OP_PUSH:                       w_reject = r_full;
            OP_POP:                        w_reject = r_empty;
            OP_ADD, OP_SUB, OP_AND, OP_OR: w_reject = (r_count < CW'(2));
            OP_CLR:                        w_reject = 1'b0;
            default:                       w_reject = 1'b1;
        endcase
    end

    // Stack: A = top (count-1), B = next below (count-2), push slot = count.
    // Queue: A = head, B = head+1, every write goes to tail; AW-bit math wraps.
    assign w_addr_a  = r_mode ? r_head : AW'(r_count - CW'(1));
    assign w_addr_b  = r_mode ? (r_head + AW'(1)) : AW'(r_count - CW'(2));
    assign w_addr_wr = r_mode ? r_tail :
                       ((r_op == OP_PUSH) ? AW'(r_count) : AW'(r_count - CW'(2)));

    calc_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .i_op (r_op),
        .i_a  (r_a),
        .i_b  (r_b),
        .o_r  (w_alu_r)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_reject || (w_cmd_op == OP_CLR)) begin
                        w_state_nxt = ST_DONE;
                    end else if (w_cmd_op == OP_PUSH) begin
                        w_state_nxt = ST_WR;
                    end else begin
                        w_state_nxt = ST_RD_A;
                    end
                end
            end
            ST_RD_A:   w_state_nxt = ST_WAIT_A;
            ST_WAIT_A: w_state_nxt = (r_op == OP_POP) ? ST_DONE : ST_RD_B;
            ST_RD_B:   w_state_nxt = ST_WAIT_B;
            ST_WAIT_B: w_state_nxt = ST_EXEC;
            ST_EXEC:   w_state_nxt = ST_WR;
            ST_WR:     w_state_nxt = ST_DONE;
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        cmd_ready = (r_state == ST_IDLE);
        mem_we    = 1'b0;
        mem_addr  = w_addr_a;
        mem_wdata = r_res;
        done      = 1'b0;
        err       = 1'b0;
        case (r_state)
            ST_RD_A: mem_addr = w_addr_a;
            ST_RD_B: mem_addr = w_addr_b;
            ST_WR: begin
                mem_we   = 1'b1;
                mem_addr = w_addr_wr;
                if (r_op == OP_PUSH) begin
                    mem_wdata = w_push_val;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                err  = r_err;
            end
            default: ;
        endcase
        // A reset cycle must never issue a RAM write or a completion pulse.
        if (rst) begin
            mem_we = 1'b0;
            done   = 1'b0;
            err    = 1'b0;
        end
    end

    // Architectural updates all land on the edge entering DONE, so the
    // done pulse already shows the new disp/count/empty/full.
    always_comb begin
        w_commit    = 1'b0;
        w_count_nxt = r_count;
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        w_disp_nxt  = r_disp;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && (w_cmd_op == OP_CLR)) begin
                    w_commit    = 1'b1;
                    w_count_nxt = '0;
                    w_head_nxt  = '0;
                    w_tail_nxt  = '0;
                    w_disp_nxt  = '0;
                end
            end
            ST_WAIT_A: begin
                if (r_op == OP_POP) begin
                    w_commit    = 1'b1;
                    w_count_nxt = r_count - CW'(1);
                    w_disp_nxt  = mem_rdata;
                    if (r_mode) begin
                        w_head_nxt = r_head + AW'(1);
                    end
                end
            end
            ST_WR: begin
                w_commit = 1'b1;
                if (r_op == OP_PUSH) begin
                    w_count_nxt = r_count + CW'(1);
                    w_disp_nxt  = w_push_val;
                    if (r_mode) begin
                        w_tail_nxt = r_tail + AW'(1);
                    end
                end else begin
                    // Two operands consumed, one result written.
                    w_count_nxt = r_count - CW'(1);
                    w_disp_nxt  = r_res;
                    if (r_mode) begin
                        w_head_nxt = r_head + AW'(2);
                        w_tail_nxt = r_tail + AW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op    <= OP_PUSH;
            r_data  <= '0;
            r_err   <= 1'b0;
            r_mode  <= mode_q;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_disp  <= '0;
        end else begin
            if (w_accept) begin
                r_op   <= w_cmd_op;
                r_data <= cmd_data;
                r_err  <= w_reject;
                if (w_cmd_op == OP_CLR) begin
                    r_mode <= mode_q;
                end
            end
            if (r_state == ST_WAIT_A) begin
                r_a <= mem_rdata;
            end
            if (r_state == ST_WAIT_B) begin
                r_b <= mem_rdata;
            end
            if (r_state == ST_EXEC) begin
                r_res <= w_alu_r;
            end
            if (w_commit) begin
                r_count <= w_count_nxt;
                r_empty <= (w_count_nxt == '0);
                r_full  <= (w_count_nxt == FULL_CNT);
                r_head  <= w_head_nxt;
                r_tail  <= w_tail_nxt;
                r_disp  <= w_disp_nxt;
            end
        end
    end

    assign disp  = r_disp;
    assign empty = r_empty;
    assign full  = r_full;
    assign count = r_count;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Scoreboard bench for calc_op_sequencer: directed commands push their
// hand-computed completion (disp, err, count, latency) into a queue and a
// negedge monitor pops and compares on every done pulse.
`timescale 1ns/1ps
module tb_calc_op_sequencer;

    localparam int DEPTH  = 32;
    localparam int IN_W   = 16;
    localparam int DATA_W = 32;
    localparam int AW     = 5;
    localparam int CW     = 6;

    localparam logic [2:0] C_PUSH = 3'd0;
    localparam logic [2:0] C_POP  = 3'd1;
    localparam logic [2:0] C_ADD  = 3'd2;
    localparam logic [2:0] C_SUB  = 3'd3;
    localparam logic [2:0] C_AND  = 3'd4;
    localparam logic [2:0] C_OR   = 3'd5;
    localparam logic [2:0] C_CLR  = 3'd6;
    localparam logic [2:0] C_RSVD = 3'd7;

`ifdef CALC_SAT_EN
    localparam logic [31:0] SUB_5_7 = 32'h0000_0000;
`else
    localparam logic [31:0] SUB_5_7 = 32'hFFFF_FFFE;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              mode_q;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [IN_W-1:0]   cmd_data;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] disp;
    logic              done;
    logic              err;
    logic              empty;
    logic              full;
    logic [CW-1:0]     count;

    logic [DATA_W-1:0] ram [DEPTH];

    typedef struct {
        logic [31:0] disp;
        logic        err;
        logic [5:0]  cnt;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    logic watch    = 1'b0;
    logic saw_we   = 1'b0;
    logic saw_done = 1'b0;

    calc_op_sequencer #(
        .DEPTH  (DEPTH),
        .IN_W   (IN_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode_q    (mode_q),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .disp      (disp),
        .done      (done),
        .err       (err),
        .empty     (empty),
        .full      (full),
        .count     (count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port RAM, synchronous read (old data on read-during-write).
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'(done), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("disp",    64'(disp),          64'(mon_e.disp));
                check("err",     64'(err),           64'(mon_e.err));
                check("count",   64'(count),         64'(mon_e.cnt));
                check("latency", 64'(cyc - mon_e.acc), 64'(mon_e.lat));
            end
        end
        if (watch) begin
            if (mem_we === 1'b1) saw_we = 1'b1;
            if (done === 1'b1)   saw_done = 1'b1;
        end
    end

    task automatic do_cmd(input logic [2:0] op, input logic [15:0] data,
                          input logic [31:0] edisp, input logic eerr, input logic [5:0] ecnt);
        exp_t e;
        int   w;
        if (eerr || op == C_CLR) e.lat = 1;
        else if (op == C_PUSH)   e.lat = 2;
        else if (op == C_POP)    e.lat = 3;
        else                     e.lat = 7;
        @(negedge clk);
        w = 0;
        while (cmd_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("cmd_ready", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        e.disp = edisp;
        e.err  = eerr;
        e.cnt  = ecnt;
        e.acc  = cyc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        // Scribble the command bus to prove it is only sampled at acceptance.
        cmd_valid = 1'b0;
        cmd_op    = C_RSVD;
        cmd_data  = 16'hFFFF;
        w = 0;
        while (sb.size() != 0 && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (sb.size() != 0) begin
            check("done_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = '0;
        rst = 1'b1; mode_q = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_count", 64'(count),     64'd0);
        check("rst_empty", 64'(empty),     64'd1);
        check("rst_full",  64'(full),      64'd0);
        check("rst_disp",  64'(disp),      64'd0);
        check("rst_ready", 64'(cmd_ready), 64'd1);
        check("rst_done",  64'(done),      64'd0);
        check("rst_we",    64'(mem_we),    64'd0);

        // ---- Stack fill to full, overflow rejected ----
        for (int i = 1; i <= 32; i++) do_cmd(C_PUSH, 16'(i), 32'(i), 1'b0, 6'(i));
        check("stk_full",  64'(full),  64'd1);
        check("stk_empty", 64'(empty), 64'd0);
        for (int i = 0; i < 32; i++) check("stk_ram", 64'(ram[i]), 64'(i + 1));
        do_cmd(C_PUSH, 16'h0063, 32'd32, 1'b1, 6'd32);

        // ---- Stack ADD x31: running sums 63, 93, ... 528 ----
        for (int k = 1; k <= 31; k++)
            do_cmd(C_ADD, 16'h0, 32'(528 - (31 - k) * (32 - k) / 2), 1'b0, 6'(32 - k));
        check("stk_full_after_add", 64'(full), 64'd0);
        check("stk_ram0_528",       64'(ram[0]), 64'd528);

        do_cmd(C_POP, 16'h0, 32'd528, 1'b0, 6'd0);
        check("stk_empty_after_pop", 64'(empty), 64'd1);
        do_cmd(C_POP, 16'h0, 32'd528, 1'b1, 6'd0);
        do_cmd(C_ADD, 16'h0, 32'd528, 1'b1, 6'd0);
        do_cmd(C_PUSH, 16'd5, 32'd5, 1'b0, 6'd1);
        do_cmd(C_ADD, 16'h0, 32'd5, 1'b1, 6'd1);
        do_cmd(C_PUSH, 16'd7, 32'd7, 1'b0, 6'd2);
        do_cmd(C_SUB, 16'h0, SUB_5_7, 1'b0, 6'd1);
        do_cmd(C_RSVD, 16'h1234, SUB_5_7, 1'b1, 6'd1);
        do_cmd(C_CLR, 16'h0, 32'd0, 1'b0, 6'd0);

        do_cmd(C_PUSH, 16'h00FF, 32'h00FF, 1'b0, 6'd1);
        do_cmd(C_PUSH, 16'h0F0F, 32'h0F0F, 1'b0, 6'd2);
        do_cmd(C_AND,  16'h0,    32'h000F, 1'b0, 6'd1);
        check("stk_ram0_and", 64'(ram[0]), 64'h000F);
        do_cmd(C_PUSH, 16'hF000, 32'hF000, 1'b0, 6'd2);
        do_cmd(C_OR,   16'h0,    32'hF00F, 1'b0, 6'd1);
        do_cmd(C_POP,  16'h0,    32'hF00F, 1'b0, 6'd0);

        // ---- Queue mode: latched by CLR, later mode_q changes ignored ----
        mode_q = 1'b1;
        do_cmd(C_CLR, 16'h0, 32'd0, 1'b0, 6'd0);
        mode_q = 1'b0;
        do_cmd(C_PUSH, 16'd1, 32'd1, 1'b0, 6'd1);
        do_cmd(C_PUSH, 16'd2, 32'd2, 1'b0, 6'd2);
        do_cmd(C_PUSH, 16'd3, 32'd3, 1'b0, 6'd3);
        do_cmd(C_ADD,  16'h0, 32'd3, 1'b0, 6'd2);
        check("q_ram3", 64'(ram[3]), 64'd3);
        do_cmd(C_ADD,  16'h0, 32'd6, 1'b0, 6'd1);
        check("q_ram4", 64'(ram[4]), 64'd6);

        // ---- Queue wrap from full ----
        mode_q = 1'b1;
        do_cmd(C_CLR, 16'h0, 32'd0, 1'b0, 6'd0);
        for (int i = 1; i <= 32; i++) do_cmd(C_PUSH, 16'(i), 32'(i), 1'b0, 6'(i));
        check("q_full", 64'(full), 64'd1);
        do_cmd(C_ADD, 16'h0, 32'd3, 1'b0, 6'd31);
        check("q_full_after_add", 64'(full), 64'd0);
        check("q_ram0_wrap", 64'(ram[0]), 64'd3);
        do_cmd(C_ADD, 16'h0, 32'd7, 1'b0, 6'd30);
        check("q_ram1_wrap", 64'(ram[1]), 64'd7);
        do_cmd(C_POP, 16'h0, 32'd5, 1'b0, 6'd29);
        do_cmd(C_PUSH, 16'h0055, 32'h55, 1'b0, 6'd30);
        check("q_ram2_tail", 64'(ram[2]), 64'h55);

        // ---- Reset during WAIT_B of an ADD ----
        @(negedge clk);
        watch = 1'b1; saw_we = 1'b0; saw_done = 1'b0;
        cmd_valid = 1'b1; cmd_op = C_ADD; cmd_data = '0;
        @(posedge clk); #1 cmd_valid = 1'b0;    // RD_A
        @(posedge clk); #1;                     // WAIT_A
        @(posedge clk); #1;                     // RD_B
        @(posedge clk); #1;                     // WAIT_B
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rstmid_ready", 64'(cmd_ready), 64'd1);
        check("rstmid_count", 64'(count),     64'd0);
        check("rstmid_empty", 64'(empty),     64'd1);
        check("rstmid_disp",  64'(disp),      64'd0);
        repeat (8) @(negedge clk);
        check("rstmid_no_we",   64'(saw_we),   64'd0);
        check("rstmid_no_done", 64'(saw_done), 64'd0);
        watch = 1'b0;

        // Reset re-latched queue mode (mode_q=1): first push goes to slot 0.
        do_cmd(C_PUSH, 16'd9, 32'd9, 1'b0, 6'd1);
        check("post_rst_ram0", 64'(ram[0]), 64'd9);

        // ---- Reset landing in the WR cycle of a PUSH: no write ----
        @(negedge clk);
        watch = 1'b1; saw_we = 1'b0; saw_done = 1'b0;
        cmd_valid = 1'b1; cmd_op = C_PUSH; cmd_data = 16'h0077;
        @(posedge clk); #1 cmd_valid = 1'b0; rst = 1'b1;   // WR with rst high
        @(posedge clk); #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        check("rstwr_no_we",   64'(saw_we),   64'd0);
        check("rstwr_no_done", 64'(saw_done), 64'd0);
        check("rstwr_ram1",    64'(ram[1]),   64'd7);
        check("rstwr_count",   64'(count),    64'd0);
        watch = 1'b0;

        repeat (3) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
